// File: rtl/speaker_control_pkg.sv
// speaker_control_pkg: shared audio widths, default divider taps and frame-size helper
package speaker_control_pkg;
    localparam int AUDIO_DATA_W = 16;
    localparam int MCLK_BIT_DEF = 1;
    localparam int SCK_BIT_DEF  = 3;
    typedef logic signed [AUDIO_DATA_W-1:0] audio_sample_t;
    function automatic int lrck_bit(input int sck_bit, input int data_w);
        return sck_bit + $clog2(2 * data_w);
    endfunction
endpackage

// File: rtl/speaker_control_if.sv
// speaker_control_if: stereo sample input plus I2S DAC pins
interface speaker_control_if #(parameter int DATA_W = 16);
    logic [DATA_W-1:0] audio_left;
    logic [DATA_W-1:0] audio_right;
    logic              mute;
    logic              audio_mclk;
    logic              audio_lrck;
    logic              audio_sck;
    logic              audio_sdin;
    logic              sample_tick;
    modport master (
        output audio_left, audio_right, mute,
        input  audio_mclk, audio_lrck, audio_sck, audio_sdin, sample_tick
    );
    modport slave (
        input  audio_left, audio_right, mute,
        output audio_mclk, audio_lrck, audio_sck, audio_sdin, sample_tick
    );
endinterface

// File: rtl/audio_clk_gen.sv
// audio_clk_gen: free-running divider producing mclk/sck/lrck, frame strobes and SCK period index
module audio_clk_gen
    import speaker_control_pkg::*;
#(
    parameter int DATA_W   = AUDIO_DATA_W,
    parameter int MCLK_BIT = MCLK_BIT_DEF,
    parameter int SCK_BIT  = SCK_BIT_DEF,
    localparam int LRCK_BIT = lrck_bit(SCK_BIT, DATA_W),
    localparam int CNT_W    = LRCK_BIT + 1,
    localparam int KW       = LRCK_BIT - SCK_BIT
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          mclk_o,
    output logic          sck_o,
    output logic          lrck_o,
    output logic          sck_fall_o,
    output logic          frame_end_o,
    output logic [KW-1:0] k_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d = cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // Clock outputs are straight flop bits, so they cannot glitch.
    assign mclk_o      = cnt_q[MCLK_BIT];
    assign sck_o       = cnt_q[SCK_BIT];
    assign lrck_o      = cnt_q[LRCK_BIT];
    assign sck_fall_o  = &cnt_q[SCK_BIT:0];
    assign frame_end_o = &cnt_q;
    assign k_o         = cnt_q[LRCK_BIT:SCK_BIT+1];
endmodule

// File: rtl/speaker_control.sv
// speaker_control: captures a coherent stereo sample pair per frame and serializes it as I2S
module speaker_control
    import speaker_control_pkg::*;
#(
    parameter int DATA_W   = AUDIO_DATA_W,
    parameter int MCLK_BIT = MCLK_BIT_DEF,
    parameter int SCK_BIT  = SCK_BIT_DEF,
    localparam int KW      = $clog2(2 * DATA_W)
) (
    input  logic clk,
    input  logic rst_n,
    speaker_control_if.slave bus
);
    localparam logic [KW-1:0] HALF = KW'(DATA_W);

    logic              sck_fall, frame_end;
    logic [KW-1:0]     k, kn;
    logic [KW-2:0]     idx;
    logic [DATA_W-1:0] l_hold_q, l_hold_d, r_hold_q, r_hold_d;
    logic              sdin_q, sdin_d, tick_q;

    audio_clk_gen #(.DATA_W(DATA_W), .MCLK_BIT(MCLK_BIT), .SCK_BIT(SCK_BIT)) u_clk (
        .clk        (clk),
        .rst_n      (rst_n),
        .mclk_o     (bus.audio_mclk),
        .sck_o      (bus.audio_sck),
        .lrck_o     (bus.audio_lrck),
        .sck_fall_o (sck_fall),
        .frame_end_o(frame_end),
        .k_o        (k)
    );

    // For either half of the frame the bit index is (-k') mod DATA_W, giving MSB first
    // one SCK after the lrck edge; k'==0 carries the outgoing right LSB.
    always_comb begin
        kn       = k + 1'b1;
        idx      = -kn[KW-2:0];
        sdin_d   = !sck_fall   ? sdin_q :
                   kn == '0    ? r_hold_q[0] :
                   kn <= HALF  ? l_hold_q[idx] : r_hold_q[idx];
        l_hold_d = !frame_end ? l_hold_q : bus.mute ? '0 : bus.audio_left;
        r_hold_d = !frame_end ? r_hold_q : bus.mute ? '0 : bus.audio_right;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_hold_q <= '0;
            r_hold_q <= '0;
            sdin_q   <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            l_hold_q <= l_hold_d;
            r_hold_q <= r_hold_d;
            sdin_q   <= sdin_d;
            tick_q   <= frame_end;
        end
    end

    assign bus.audio_sdin  = sdin_q;
    assign bus.sample_tick = tick_q;
endmodule

// File: doc/speaker_control.md
Name: speaker_control

Overview:
- Consumer end of the 16-bit stereo audio-sample interface produced by the note/buzzer generators.
- Captures audio_left/audio_right once per frame and serializes them in I2S format to the on-board stereo DAC (Pmod I2S class).
- Generates MCLK, LRCK and SCK from the system clock.
- Sits between the tone-generation logic and the top-level DAC pins.

Parameters:
- DATA_W, 16, bits per channel sample; power of two, 16 or 32.
- MCLK_BIT, 1, divider-counter bit driving MCLK; MCLK = clk/2^(MCLK_BIT+1), default clk/4.
- SCK_BIT, 3, divider-counter bit driving SCK; SCK = clk/2^(SCK_BIT+1), default clk/16. Must be greater than MCLK_BIT.
- Derived, not overridable: LRCK_BIT = SCK_BIT + log2(2*DATA_W), default 8. CNT_W = LRCK_BIT + 1, default 9. LRCK = clk/2^CNT_W, default clk/512.

Ports:
- clk  input  1  system clock (crystal).
- rst_n  input  1  asynchronous reset, active-low.
- audio_left  input  DATA_W  left sample, two's complement; may change any cycle.
- audio_right  input  DATA_W  right sample, two's complement.
- mute  input  1  1 = zero samples at capture.
- audio_mclk  output  1  DAC master clock.
- audio_lrck  output  1  word select; 0 = left, 1 = right.
- audio_sck  output  1  serial bit clock.
- audio_sdin  output  1  serial data, MSB first.
- sample_tick  output  1  one-clk pulse marking sample capture.

Behaviour:
- Reset is decided as stated: rst_n, asynchronous, active-low; clock clk.
- cnt[CNT_W-1:0] is a free-running up-counter that wraps from all-ones to 0. Its reset value is 0.
- Clock outputs:
  - audio_mclk = cnt[MCLK_BIT], audio_sck = cnt[SCK_BIT], audio_lrck = cnt[LRCK_BIT].
  - Each is a direct flop bit, so no glitches.
  - Defaults: mclk period 4 clk, sck period 16 clk, lrck period 512 clk, 32 SCK periods per frame.
- Period index k = cnt[LRCK_BIT:SCK_BIT+1], range 0..2*DATA_W-1.
- Events:
  - SCK-fall event: cnt[SCK_BIT:0] all ones. The next edge starts a new SCK period with sck low.
  - Frame-end event: cnt all ones, a subset of SCK-fall.
- Capture:
  - On the frame-end edge, L_hold <= mute ? 0 : audio_left and R_hold <= mute ? 0 : audio_right. Both channels are always captured on the same edge (coherent pair).
  - sample_tick = 1 for exactly the cycle where cnt == 0; 0 otherwise.
  - Input changes between captures have no effect.
- Serializer, I2S with one-SCK delay:
  - audio_sdin updates only on SCK-fall edges, so data changes with SCK falling and is stable at SCK rising.
  - For the new period k' (k' = k+1 mod 2*DATA_W):
    - k'=0: R_hold[0] of the frame just ending, using the old value on the same edge that reloads R_hold.
    - 1<=k'<=DATA_W: L_hold[DATA_W-k'].
    - DATA_W<k'<=2*DATA_W-1: R_hold[2*DATA_W-k'].
  - Result: left MSB in period 1 (lrck=0), right MSB in period DATA_W+1 (lrck=1), right LSB in period 0 of the next frame.
- Reset values: cnt=0, L_hold=R_hold=0, audio_sdin=0, sample_tick=0, so mclk=sck=lrck=0.
- First frame after reset:
  - transmits zeros;
  - first capture at cnt 511->0 (default);
  - first sample_tick in the cycle cnt==0 of the second frame.
- Reset mid-frame: all state returns to reset values immediately. The partial frame is abandoned and no partial word is completed.
- mute asserted mid-frame: the current frame finishes with held data. Zeros start from the next capture.
- No back-pressure. Upstream must tolerate sampling once per 2^CNT_W clk.

Decomposition:
- Shared audio package holds:
  - AUDIO_DATA_W = 16;
  - default MCLK_BIT and SCK_BIT;
  - signed sample typedef audio_sample_t [15:0];
  - localparam function for LRCK_BIT.
- One natural sub-module, audio_clk_gen: the counter plus mclk/sck/lrck bits, sck_fall and frame_end strobes, and k. The serializer/capture stays in speaker_control.

Test Plan:
- Reset hold then release, inputs L=16'h3FFF, R=16'hC000:
  - mclk period = 4 clk, sck = 16, lrck = 512, 50% duty;
  - first sample_tick at clk 512 after release;
  - frame 0 sdin all zeros.
- Static L=16'hA5C3, R=16'h0F0F: sample sdin on each sck rise.
  - Periods 1-16 decode 16'hA5C3.
  - Periods 17-31 plus next period 0 decode 16'h0F0F.
  - lrck=0 for periods 0-15, 1 for periods 16-31.
- Inputs toggled every clk between 16'h1234 and 16'hFFFF: decoded word equals the value present in the cycle with cnt==511. L and R come from the same cycle.
- mute=1 asserted at cnt==100 with L=R=16'h7FFF:
  - current frame still sends 7FFF;
  - next frame sends 0000;
  - deassert restores 7FFF from the following capture.
- rst_n pulsed low at cnt==300: within the same cycle (async) all outputs are 0 and cnt=0. Resumes as the reset scenario, with no residual bits.
- Check that sdin transitions occur only on clk edges where sck goes 1->0. The assertion holds over 10 frames of random samples.
